// File: rtl/ex_stage_pkg.sv
// Shared core definitions for the execute stage: opcodes, widths, muldiv FSM encoding.
// Imported by ex_stage and ex_muldiv_iter.
package ex_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_NOP   = 4'd0,
        ALU_ADD   = 4'd1,
        ALU_SUB   = 4'd2,
        ALU_AND   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLT   = 4'd9,
        ALU_SLTU  = 4'd10,
        ALU_LOAD  = 4'd11,
        ALU_STORE = 4'd12,
        ALU_MUL   = 4'd13,
        ALU_DIVU  = 4'd14,
        ALU_REMU  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply (shift-add) / unsigned divide (restoring), one bit per cycle.
// Only instantiated when EX_MULDIV_EN is defined.
module ex_muldiv_iter
    import ex_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e       state, state_nxt;
    logic [4:0]      count;
    logic [3:0]      op_q;
    // acc: product accumulator or partial remainder; opa: multiplicand or quotient;
    // opb: multiplier or divisor.
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] rem_diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: if (count == 5'd31) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state != MD_BUSY) begin
            count <= 5'd0;
        end else begin
            count <= count + 5'd1;
        end
    end

    assign rem_shift = {acc[XLEN-1:0], opa[XLEN-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, opb};

    always_ff @(posedge clk) begin
        if (state == MD_IDLE && start) begin
            acc  <= '0;
            opa  <= op_a;
            opb  <= op_b;
            op_q <= op;
        end else if (state == MD_BUSY) begin
            if (op_q == ALU_MUL) begin
                if (opb[0]) begin
                    acc <= {1'b0, acc[XLEN-1:0] + opa};
                end
                opa <= opa << 1;
                opb <= opb >> 1;
            end else if (!rem_diff[XLEN+1]) begin
                // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
                acc <= rem_diff[XLEN:0];
                opa <= {opa[XLEN-2:0], 1'b1};
            end else begin
                acc <= rem_shift;
                opa <= {opa[XLEN-2:0], 1'b0};
            end
        end
    end

    assign busy   = (state == MD_BUSY);
    assign done   = (state == MD_DONE);
    assign result = (op_q == ALU_DIVU) ? opa : acc[XLEN-1:0];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, address generation and the EX/MEM register.
// Optional macro EX_MULDIV_EN adds the iterative multiply/divide unit with pipeline stall.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [XLEN-1:0]       ex_op_1,
    input  logic [XLEN-1:0]       ex_op_2,
    input  logic [XLEN-1:0]       ex_op_3,
    input  logic [3:0]            ex_alu_op,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    input  logic [XLEN-1:0]       ex_mem_offset,
    output logic                  stall_req,
    output logic [XLEN-1:0]       mem_result,
    output logic [XLEN-1:0]       mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd_addr,
    output logic                  mem_rd_we,
    output logic                  mem_re,
    output logic                  mem_we
);

    logic signed [XLEN-1:0] op1_s;
    logic signed [XLEN-1:0] op2_s;
    logic [4:0]             shamt;
    logic [XLEN-1:0]        alu_res;
    logic [XLEN-1:0]        result_sel;
    logic                   rd_we_nxt;

    assign op1_s = ex_op_1;
    assign op2_s = ex_op_2;
    assign shamt = ex_op_2[4:0];

    always_comb begin
        alu_res = '0;
        case (ex_alu_op)
            ALU_ADD:   alu_res = ex_op_1 + ex_op_2;
            ALU_SUB:   alu_res = ex_op_1 - ex_op_2;
            ALU_AND:   alu_res = ex_op_1 & ex_op_2;
            ALU_OR:    alu_res = ex_op_1 | ex_op_2;
            ALU_XOR:   alu_res = ex_op_1 ^ ex_op_2;
            ALU_SLL:   alu_res = ex_op_1 << shamt;
            ALU_SRL:   alu_res = ex_op_1 >> shamt;
            ALU_SRA:   alu_res = $unsigned(op1_s >>> shamt);
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (ex_op_1 < ex_op_2)};
            ALU_LOAD,
            ALU_STORE: alu_res = ex_op_1 + ex_mem_offset;
            default:   alu_res = '0;
        endcase
    end

    assign rd_we_nxt = ex_rd_we && (ex_rd_addr != '0)
                       && (ex_alu_op != ALU_STORE) && (ex_alu_op != ALU_NOP);

`ifdef EX_MULDIV_EN
    logic            md_start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    // DONE suppresses start so the still-present opcode does not re-launch the unit.
    assign md_start   = is_muldiv(ex_alu_op) && !md_busy && !md_done;
    assign stall_req  = md_start || md_busy;
    assign result_sel = md_done ? md_result : alu_res;

    ex_muldiv_iter u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .op     (ex_alu_op),
        .op_a   (ex_op_1),
        .op_b   (ex_op_2),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign stall_req  = 1'b0;
    assign result_sel = alu_res;
`endif

    // EX/MEM boundary: stalls and NOPs load a bubble.
    always_ff @(posedge clk) begin
        if (reset || stall_req || ex_alu_op == ALU_NOP) begin
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd_addr    <= '0;
            mem_rd_we      <= 1'b0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
        end else begin
            mem_result     <= result_sel;
            mem_store_data <= (ex_alu_op == ALU_STORE) ? ex_op_3 : '0;
            mem_rd_addr    <= ex_rd_addr;
            mem_rd_we      <= rd_we_nxt;
            mem_re         <= (ex_alu_op == ALU_LOAD);
            mem_we         <= (ex_alu_op == ALU_STORE);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and random ops against a behavioural model.
// Expectations follow EX_MULDIV_EN the same way the design does.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_op_1, ex_op_2, ex_op_3, ex_mem_offset;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;
    logic        stall_req;
    logic [31:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we, mem_re, mem_we;
    logic [71:0] bus;

    int nvec = 0;
    int nerr = 0;

    ex_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ex_op_1        (ex_op_1),
        .ex_op_2        (ex_op_2),
        .ex_op_3        (ex_op_3),
        .ex_alu_op      (ex_alu_op),
        .ex_rd_addr     (ex_rd_addr),
        .ex_rd_we       (ex_rd_we),
        .ex_mem_offset  (ex_mem_offset),
        .stall_req      (stall_req),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_we      (mem_rd_we),
        .mem_re         (mem_re),
        .mem_we         (mem_we)
    );

    always #5 clk = ~clk;

    assign bus = {mem_result, mem_store_data, mem_rd_addr, mem_rd_we, mem_re, mem_we};

    // Expected EX/MEM contents {result, store_data, rd_addr, rd_we, re, we}.
    function automatic logic [71:0] model(input logic [3:0] op, input logic [31:0] a, b, c, off,
                                          input logic [4:0] rd, input logic we);
        logic [31:0] r;
        logic        rdw;
        r = 32'd0;
        case (op)
            4'd1:  r = a + b;
            4'd2:  r = a - b;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = a << b[4:0];
            4'd7:  r = a >> b[4:0];
            4'd8:  r = $signed(a) >>> b[4:0];
            4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11, 4'd12: r = a + off;
`ifdef EX_MULDIV_EN
            4'd13: r = a * b;
            4'd14: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd15: r = (b == 0) ? a : a % b;
`endif
            default: r = 32'd0;
        endcase
        if (op == 4'd0) return 72'd0;
        rdw = we && (rd != 5'd0) && (op != 4'd12);
        return {r, (op == 4'd12) ? c : 32'd0, rd, rdw, op == 4'd11, op == 4'd12};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, b, c, off,
                         input logic [4:0] rd, input logic we);
        ex_alu_op = op; ex_op_1 = a; ex_op_2 = b; ex_op_3 = c;
        ex_mem_offset = off; ex_rd_addr = rd; ex_rd_we = we;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(ALU_ADD, $urandom, $urandom, $urandom, $urandom, 5'd5, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        nvec++;
        if (bus !== 72'd0) begin
            nerr++; $display("FAIL reset_bus: got %h want 0", bus);
        end
        nvec++;
        if (stall_req !== 1'b0) begin
            nerr++; $display("FAIL reset_stall: got %b want 0", stall_req);
        end
        reset = 1'b0;
        drive(ALU_NOP, $urandom, $urandom, $urandom, $urandom, 5'd3, 1'b1);
        @(posedge clk); #1;
        nvec++;
        if (bus !== 72'd0) begin
            nerr++; $display("FAIL nop_bubble: got %h want 0", bus);
        end
    endtask

    task automatic test_directed;
        logic [3:0]  ops[8] = '{ALU_ADD, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_STORE, ALU_ADD, ALU_LOAD, ALU_NOP};
        logic [31:0] av[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'h100, 32'd3, 32'h1000, 32'h1234};
        logic [31:0] bv[8]  = '{32'd1, 32'h24, 32'd1, 32'd1, 32'd0, 32'd4, 32'd0, 32'd9};
        logic [31:0] cv[8]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hDEAD, 32'd0, 32'd0, 32'h77};
        logic [31:0] ov[8]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'h10, 32'h5};
        logic [4:0]  rv[8]  = '{5'd5, 5'd3, 5'd4, 5'd4, 5'd7, 5'd0, 5'd9, 5'd2};
        logic [31:0] er[8]  = '{32'h8000_0000, 32'hF800_0000, 32'd1, 32'd0, 32'hFC, 32'd7, 32'h1010, 32'd0};
        logic [71:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], av[i], bv[i], cv[i], ov[i], rv[i], 1'b1);
            #1;
            nvec++;
            if (stall_req !== 1'b0) begin
                nerr++; $display("FAIL directed_stall[%0d]: got %b want 0", i, stall_req);
            end
            @(posedge clk); #1;
            exp = model(ops[i], av[i], bv[i], cv[i], ov[i], rv[i], 1'b1);
            nvec++;
            if (mem_result !== er[i]) begin
                nerr++; $display("FAIL directed_result[%0d]: got %h want %h", i, mem_result, er[i]);
            end
            nvec++;
            if (bus !== exp) begin
                nerr++; $display("FAIL directed_bus[%0d]: got %h want %h", i, bus, exp);
            end
        end
    endtask

    task automatic test_random_alu;
        logic [3:0]  op;
        logic [31:0] a, b, c, off;
        logic [4:0]  rd;
        logic        we;
        logic [71:0] exp;
        for (int i = 0; i < 150; i++) begin
            op  = 4'($urandom_range(0, 12));
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            c   = $urandom;
            off = $urandom;
            rd  = 5'($urandom_range(0, 31));
            we  = 1'($urandom_range(0, 1));
            drive(op, a, b, c, off, rd, we);
            #1;
            nvec++;
            if (stall_req !== 1'b0) begin
                nerr++; $display("FAIL random_stall[%0d]: got %b want 0", i, stall_req);
            end
            @(posedge clk); #1;
            exp = model(op, a, b, c, off, rd, we);
            nvec++;
            if (bus !== exp) begin
                nerr++; $display("FAIL random_bus[%0d] op=%0d: got %h want %h", i, op, bus, exp);
            end
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  ops[5] = '{ALU_MUL, ALU_DIVU, ALU_REMU, ALU_DIVU, ALU_REMU};
        logic [31:0] av[5]  = '{32'h12345, 32'd100, 32'd100, 32'd5, 32'd5};
        logic [31:0] bv[5]  = '{32'h100, 32'd7, 32'd7, 32'd0, 32'd0};
`ifdef EX_MULDIV_EN
        logic [31:0] er[5]  = '{32'h0123_4500, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
        int          n;
        logic        bub_ok;
`else
        logic [31:0] er[5]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`endif
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [71:0] exp;
        for (int i = 0; i < 9; i++) begin
            if (i < 5) begin
                op = ops[i]; a = av[i]; b = bv[i];
            end else begin
                op = 4'($urandom_range(13, 15));
                a  = $urandom;
                b  = (i == 8) ? 32'd0 : ((i == 7) ? 32'($urandom_range(1, 300)) : $urandom);
            end
            drive(op, a, b, 32'h55, 32'h66, 5'd10 + 5'(i), 1'b1);
            exp = model(op, a, b, 32'h55, 32'h66, 5'd10 + 5'(i), 1'b1);
`ifdef EX_MULDIV_EN
            n = 0; bub_ok = 1'b1;
            #1;
            while (stall_req === 1'b1 && n < 100) begin
                n++;
                @(posedge clk); #1;
                if (bus !== 72'd0) bub_ok = 1'b0;
            end
            nvec++;
            if (n != 33) begin
                nerr++; $display("FAIL md_stall_len[%0d]: got %0d cycles want 33", i, n);
            end
            nvec++;
            if (!bub_ok) begin
                nerr++; $display("FAIL md_bubble[%0d]: got non-bubble want bubble while stalled", i);
            end
`else
            #1;
            nvec++;
            if (stall_req !== 1'b0) begin
                nerr++; $display("FAIL md_stall[%0d]: got %b want 0", i, stall_req);
            end
`endif
            @(posedge clk); #1;
            nvec++;
            if (bus !== exp) begin
                nerr++; $display("FAIL md_bus[%0d] op=%0d: got %h want %h", i, op, bus, exp);
            end
            if (i < 5) begin
                nvec++;
                if (mem_result !== er[i]) begin
                    nerr++; $display("FAIL md_result[%0d]: got %h want %h", i, mem_result, er[i]);
                end
            end
        end
        drive(ALU_NOP, 0, 0, 0, 0, 5'd0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops[4] = '{ALU_MUL, ALU_ADD, ALU_DIVU, ALU_SUB};
        logic [31:0] a, b;
        logic [71:0] exp;
        int          n;
        int          want;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom_range(1, 1000);
            drive(ops[i], a, b, 32'd0, 32'd0, 5'd20 + 5'(i), 1'b1);
            exp = model(ops[i], a, b, 32'd0, 32'd0, 5'd20 + 5'(i), 1'b1);
`ifdef EX_MULDIV_EN
            want = is_muldiv(ops[i]) ? 33 : 0;
`else
            want = 0;
`endif
            n = 0;
            #1;
            while (stall_req === 1'b1 && n < 100) begin
                n++;
                @(posedge clk); #1;
            end
            nvec++;
            if (n != want) begin
                nerr++; $display("FAIL b2b_stall_len[%0d]: got %0d want %0d", i, n, want);
            end
            @(posedge clk); #1;
            nvec++;
            if (bus !== exp) begin
                nerr++; $display("FAIL b2b_bus[%0d]: got %h want %h", i, bus, exp);
            end
        end
        drive(ALU_NOP, 0, 0, 0, 0, 5'd0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midbusy;
        logic [71:0] exp;
        drive(ALU_MUL, 32'h1234_5678, 32'h9ABC, 32'd0, 32'd0, 5'd8, 1'b1);
        repeat (11) @(posedge clk);
        #1;
`ifdef EX_MULDIV_EN
        nvec++;
        if (stall_req !== 1'b1) begin
            nerr++; $display("FAIL midbusy_stall: got %b want 1", stall_req);
        end
`endif
        reset = 1'b1;
        drive(ALU_NOP, 0, 0, 0, 0, 5'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        nvec++;
        if (stall_req !== 1'b0) begin
            nerr++; $display("FAIL abort_stall: got %b want 0", stall_req);
        end
        nvec++;
        if (bus !== 72'd0) begin
            nerr++; $display("FAIL abort_bus: got %h want 0", bus);
        end
        @(posedge clk); #1;
        nvec++;
        if (bus !== 72'd0) begin
            nerr++; $display("FAIL abort_late_result: got %h want 0", bus);
        end
        drive(ALU_ADD, 32'd40, 32'd2, 32'd0, 32'd0, 5'd12, 1'b1);
        exp = model(ALU_ADD, 32'd40, 32'd2, 32'd0, 32'd0, 5'd12, 1'b1);
        @(posedge clk); #1;
        nvec++;
        if (bus !== exp) begin
            nerr++; $display("FAIL post_reset_add: got %h want %h", bus, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(ALU_NOP, 0, 0, 0, 0, 5'd0, 1'b0);
        test_reset();
        test_directed();
        test_random_alu();
        test_muldiv();
        test_back_to_back();
        test_reset_midbusy();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage core: consumes the ID/EX pipeline register outputs, computes the ALU result or memory address, and registers everything into the EX/MEM boundary. Houses an iterative multiply/divide unit that holds the pipeline through a stall request while it runs. Sits between the ID/EX register and the memory stage.

## Interface
- No parameters; data width fixed at 32, register address 5 bits.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ex_op_1  in  32  rs1 operand
- ex_op_2  in  32  rs2 operand / immediate
- ex_op_3  in  32  store data
- ex_alu_op  in  4  operation code
- ex_rd_addr  in  5  destination register
- ex_rd_we  in  1  destination write enable
- ex_mem_offset  in  32  load/store offset
- stall_req  out  1  combinational; freezes PC, IF/ID, ID/EX
- mem_result  out  32  ALU result or memory address
- mem_store_data  out  32  store data
- mem_rd_addr  out  5  destination register
- mem_rd_we  out  1  destination write enable
- mem_re  out  1  load strobe
- mem_we  out  1  store strobe

## Operation
- ex_alu_op: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed), 10 SLTU, 11 LOAD, 12 STORE, 13 MUL, 14 DIVU, 15 REMU.
- All arithmetic modulo 2^32; shifts use ex_op_2[4:0].
- LOAD/STORE: mem_result = ex_op_1 + ex_mem_offset; mem_re=1 for LOAD, mem_we=1 for STORE; mem_store_data = ex_op_3 for STORE, 0 otherwise.
- mem_rd_we = ex_rd_we && (ex_rd_addr != 0) && op not STORE/NOP.
- NOP: all mem_* outputs written 0 (bubble).
- MUL: low 32 bits of unsigned product, shift-add, one bit per cycle.
- DIVU/REMU: restoring division, one quotient bit per cycle. Divide by zero: DIVU = 0xFFFFFFFF, REMU = ex_op_1.
- Muldiv FSM states:
  - IDLE: opcode 13-15 seen -> latch operands, count=0, assert stall_req, go BUSY.
  - BUSY: one iteration per cycle, stall_req high; count==31 -> DONE.
  - DONE: stall_req low, result drives mem_result, go IDLE.
- While stall_req is high, EX/MEM loads a bubble (all mem_* = 0); upstream holds ex_* inputs stable.

## Timing
- Single-cycle ops: EX/MEM updated at the first rising edge after presentation; stall_req stays 0.
- Muldiv: stall_req high for exactly 33 consecutive cycles (IDLE-detect cycle + 32 BUSY); result registered at the edge ending DONE cycle (34th edge after presentation counting the presentation edge as 0).
- DONE does not re-trigger on the same still-present opcode; IDLE only re-arms after a new instruction is presented (ID/EX advanced).
- Back-to-back muldiv ops: second begins its IDLE-detect in the cycle after DONE.
- Reset: all mem_* outputs 0, FSM to IDLE, count 0, stall_req 0 in the following cycle; reset mid-BUSY aborts with no result written.

## Configuration
- EX_MULDIV_EN defined: opcodes 13-15 run through the iterative unit as above.
- EX_MULDIV_EN undefined: no FSM or datapath; opcodes 13-15 complete in one cycle with mem_result = 0, mem_rd_we per normal rule; stall_req tied to 0.

## Structure
- Shared core package: alu_op opcode constants (ALU_NOP … ALU_REMU), XLEN=32, REG_ADDR_W=5, muldiv state encoding.
- One sub-module: ex_muldiv_iter (start, op, operands in; busy, done, result out), instantiated only under EX_MULDIV_EN.
- Single-cycle ALU and the EX/MEM register live in ex_stage.

## Test plan
- ADD 0x7FFFFFFF + 1, rd=5 -> next edge mem_result=0x80000000, mem_rd_we=1, stall_req=0.
- SRA 0x80000000 by 0x24 (shift 4) -> 0xF8000000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- STORE op1=0x100, offset=0xFFFFFFFC, op3=0xDEAD -> mem_result=0xFC, mem_we=1, mem_store_data=0xDEAD, mem_rd_we=0; ADD with rd=0 -> mem_rd_we=0.
- MUL 0x12345 × 0x100 -> stall_req high 33 cycles, bubbles meanwhile, then mem_result=0x01234500.
- DIVU 100/7 -> 14, REMU -> 2; DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
- Reset asserted at BUSY count 10 -> stall_req 0, mem_* 0 next cycle; subsequent ADD completes normally.
